// File: rtl/game_pkg.sv
// Shared types and constants for the turn scheduler and its LFSR.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package game_pkg;

    localparam int NUM_COLS_DEF = 7;
    localparam logic [7:0] LFSR_SEED = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        TURN,
        ISSUE,
        AUTO,
        DONE
    } state_t;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

endpackage

// File: rtl/lfsr8.sv
// Free-running 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) used to pick auto-move columns.
// Latency: new value every cycle, no enable.
// Backpressure: none; consumers sample whenever they need a value.
module lfsr8
    import game_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    output logic [7:0] value
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= LFSR_SEED;
        end else begin
            value <= {value[6:0], value[7] ^ value[5] ^ value[4] ^ value[3]};
        end
    end

endmodule

// File: rtl/turn_scheduler.sv
// Two-player turn scheduler: accepts moves, runs the turn timer, auto-plays on timeout.
// Latency: one cycle from input strobe to registered outputs.
// Backpressure: move_req is held with stable column/player until the board returns move_ack.
module turn_scheduler
    import game_pkg::*;
#(
    parameter  int NUM_COLS = NUM_COLS_DEF,
    localparam int COL_W    = $clog2(NUM_COLS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             p1_move_valid,
    input  logic [COL_W-1:0] p1_col,
    input  logic             p2_move_valid,
    input  logic [COL_W-1:0] p2_col,
    input  logic             timer_timeout,
    output logic             timer_enable,
    output logic             timer_reset,
    output logic             move_req,
    output logic [COL_W-1:0] move_col,
    output logic             move_player,
    input  logic             move_ack,
    input  logic             move_legal,
    input  logic             win,
    input  logic             draw,
    output logic             current_player,
    output logic             game_over,
    output logic [1:0]       winner
);

    localparam logic [COL_W:0]   NC_W     = (COL_W+1)'(NUM_COLS);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(NUM_COLS - 1);
    localparam logic [7:0]       LFSR_MOD = 8'(NUM_COLS);

    state_t           state_q, state_d;
    logic             cur_d;
    logic [1:0]       winner_d;
    logic [COL_W-1:0] col_d;
    logic             mpl_d;
    logic             req_d;
    logic             trst_d;
    logic [COL_W-1:0] attempt_q, attempt_d;

    logic [7:0]       lfsr_val;
    logic [COL_W-1:0] lfsr_col;
    logic             sel_vld;
    logic [COL_W-1:0] sel_col;
    logic             mv_ok;
    logic             ack_ok;

    lfsr8 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .value (lfsr_val)
    );

    assign lfsr_col = COL_W'(lfsr_val % LFSR_MOD);
    assign sel_vld  = current_player ? p2_move_valid : p1_move_valid;
    assign sel_col  = current_player ? p2_col : p1_col;
    assign mv_ok    = sel_vld && ({1'b0, sel_col} < NC_W);
    // An ack only counts while a request is actually on the wire; this also
    // drops acks that arrive in the one-cycle gap between auto retries.
    assign ack_ok   = move_ack && move_req;

    always_comb begin
        state_d   = state_q;
        cur_d     = current_player;
        winner_d  = winner;
        col_d     = move_col;
        mpl_d     = move_player;
        req_d     = 1'b0;
        trst_d    = 1'b0;
        attempt_d = attempt_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d  = TURN;
                    cur_d    = 1'b0;
                    winner_d = WIN_NONE;
                    trst_d   = 1'b1;
                end
            end
            TURN: begin
                // A real move beats a same-cycle timeout.
                if (mv_ok) begin
                    state_d = ISSUE;
                    col_d   = sel_col;
                    mpl_d   = current_player;
                    req_d   = 1'b1;
                end else if (timer_timeout) begin
                    state_d   = AUTO;
                    col_d     = lfsr_col;
                    mpl_d     = current_player;
                    attempt_d = '0;
                    req_d     = 1'b1;
                end
            end
            ISSUE, AUTO: begin
                req_d = 1'b1;
                if (ack_ok) begin
                    req_d = 1'b0;
                    if (move_legal) begin
                        if (win) begin
                            state_d  = DONE;
                            winner_d = current_player ? WIN_P2 : WIN_P1;
                        end else if (draw) begin
                            state_d  = DONE;
                            winner_d = WIN_DRAW;
                        end else begin
                            state_d = TURN;
                            cur_d   = ~current_player;
                            trst_d  = 1'b1;
                        end
                    end else if (state_q == ISSUE) begin
                        // Rejected manual move: same player retries on the remaining time.
                        state_d = TURN;
                    end else if (attempt_q == LAST_COL) begin
                        state_d  = DONE;
                        winner_d = WIN_DRAW;
                    end else begin
                        attempt_d = attempt_q + 1'b1;
                        col_d     = (move_col == LAST_COL) ? '0 : move_col + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            current_player <= 1'b0;
            winner         <= WIN_NONE;
            game_over      <= 1'b0;
            move_req       <= 1'b0;
            move_col       <= '0;
            move_player    <= 1'b0;
            timer_enable   <= 1'b0;
            timer_reset    <= 1'b1;
            attempt_q      <= '0;
        end else begin
            state_q        <= state_d;
            current_player <= cur_d;
            winner         <= winner_d;
            game_over      <= (state_d == DONE);
            move_req       <= req_d;
            move_col       <= col_d;
            move_player    <= mpl_d;
            timer_enable   <= (state_d == TURN);
            timer_reset    <= trst_d;
            attempt_q      <= attempt_d;
        end
    end

endmodule

// File: tb/tb_turn_scheduler.sv
// Directed bench for turn_scheduler with an expectation model checked every cycle.
module tb_turn_scheduler;

    localparam int NC = 7;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       p1_move_valid = 1'b0;
    logic       p2_move_valid = 1'b0;
    logic [2:0] p1_col = 3'd0;
    logic [2:0] p2_col = 3'd0;
    logic       timer_timeout = 1'b0;
    logic       move_ack = 1'b0;
    logic       move_legal = 1'b0;
    logic       win = 1'b0;
    logic       draw = 1'b0;
    logic       timer_enable, timer_reset, move_req, move_player;
    logic       current_player, game_over;
    logic [2:0] move_col;
    logic [1:0] winner;

    int n_assert = 0;
    int n_fail   = 0;

    // Expected outputs, updated by the scenario right after each clock edge.
    logic e_ten = 1'b0, e_trst = 1'b1, e_req = 1'b0, e_mpl = 1'b0, e_cur = 1'b0, e_over = 1'b0;
    int   e_col = 0, e_win = 0;
    bit   chk_en = 1'b0, in_auto = 1'b0;
    int   auto_tries = 0;
    int   n_edges = 0;
    int   n_reqs = 0;
    logic req_prev = 1'b0;
    logic [7:0] seq [255];

    turn_scheduler #(.NUM_COLS(NC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .p1_move_valid  (p1_move_valid),
        .p1_col         (p1_col),
        .p2_move_valid  (p2_move_valid),
        .p2_col         (p2_col),
        .timer_timeout  (timer_timeout),
        .timer_enable   (timer_enable),
        .timer_reset    (timer_reset),
        .move_req       (move_req),
        .move_col       (move_col),
        .move_player    (move_player),
        .move_ack       (move_ack),
        .move_legal     (move_legal),
        .win            (win),
        .draw           (draw),
        .current_player (current_player),
        .game_over      (game_over),
        .winner         (winner)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) n_edges <= 0;
        else        n_edges <= n_edges + 1;
    end

    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[6:0], ^(v & 8'hB8)};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (move_req && !req_prev) n_reqs++;
        req_prev = move_req;
        if (chk_en && rst_n) begin
            check("timer_enable",   int'(timer_enable),   int'(e_ten));
            check("timer_reset",    int'(timer_reset),    int'(e_trst));
            check("move_req",       int'(move_req),       int'(e_req));
            check("current_player", int'(current_player), int'(e_cur));
            check("game_over",      int'(game_over),      int'(e_over));
            check("winner",         int'(winner),         e_win);
            if (e_req) begin
                check("move_col",    int'(move_col),    e_col);
                check("move_player", int'(move_player), int'(e_mpl));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        e_trst = 1'b0;
    endtask

    task automatic start_game();
        start = 1'b1;
        tick();
        start = 1'b0;
        e_ten = 1'b1; e_trst = 1'b1; e_cur = 1'b0; e_over = 1'b0; e_win = 0;
        e_req = 1'b0; in_auto = 1'b0;
    endtask

    task automatic player_move(input int p, input int col, input bit to, input bit accept);
        p1_move_valid = (p == 0);
        p2_move_valid = (p == 1);
        p1_col = 3'(col);
        p2_col = 3'(col);
        timer_timeout = to;
        tick();
        p1_move_valid = 1'b0;
        p2_move_valid = 1'b0;
        timer_timeout = 1'b0;
        if (accept) begin
            e_ten = 1'b0; e_req = 1'b1; e_col = col; e_mpl = e_cur;
        end
    endtask

    task automatic timeout_now();
        int c0;
        c0 = int'(seq[n_edges % 255]) % NC;
        timer_timeout = 1'b1;
        tick();
        timer_timeout = 1'b0;
        e_ten = 1'b0; e_req = 1'b1; e_col = c0; e_mpl = e_cur;
        auto_tries = 0; in_auto = 1'b1;
    endtask

    task automatic stray_ack();
        move_ack = 1'b1; move_legal = 1'b1; win = 1'b1;
        tick();
        move_ack = 1'b0; move_legal = 1'b0; win = 1'b0;
    endtask

    task automatic board_ack(input bit legal, input bit w, input bit d, input int wait_cyc);
        repeat (wait_cyc) tick();
        move_ack = 1'b1; move_legal = legal; win = w; draw = d;
        tick();
        move_ack = 1'b0; move_legal = 1'b0; win = 1'b0; draw = 1'b0;
        e_req = 1'b0;
        if (legal) begin
            in_auto = 1'b0;
            if (w) begin
                e_over = 1'b1; e_win = e_cur ? 2 : 1;
            end else if (d) begin
                e_over = 1'b1; e_win = 3;
            end else begin
                e_ten = 1'b1; e_cur = ~e_cur; e_trst = 1'b1;
            end
        end else if (!in_auto) begin
            e_ten = 1'b1;
        end else begin
            auto_tries++;
            if (auto_tries == NC) begin
                e_over = 1'b1; e_win = 3; in_auto = 1'b0;
            end else begin
                tick();
                e_req = 1'b1; e_col = (e_col + 1) % NC;
            end
        end
    endtask

    initial begin
        int k;
        int r0;
        seq[0] = 8'hA5;
        for (int i = 1; i < 255; i++) seq[i] = lfsr_step(seq[i-1]);
        check("lfsr_model_1", int'(seq[1]), 'h4A);
        check("lfsr_model_3", int'(seq[3]), 'h2A);

        #17;
        check("rst_timer_reset",  int'(timer_reset),  1);
        check("rst_timer_enable", int'(timer_enable), 0);
        check("rst_move_req",     int'(move_req),     0);
        check("rst_move_col",     int'(move_col),     0);
        check("rst_game_over",    int'(game_over),    0);
        check("rst_winner",       int'(winner),       0);
        #5 rst_n = 1'b1;
        tick();
        chk_en = 1'b1;

        // Idle ignores moves and acks
        player_move(0, 3, 0, 0);
        stray_ack();

        start_game();
        tick();
        // Wrong player, restart attempt, out-of-range column, stray ack: all ignored
        start = 1'b1; p2_move_valid = 1'b1; p2_col = 3'd1;
        tick();
        start = 1'b0; p2_move_valid = 1'b0;
        player_move(0, 7, 0, 0);
        stray_ack();
        check("p2_strobe_ten", int'(timer_enable), 1);

        player_move(0, 3, 0, 1);
        check("p1_req_col", int'(move_col), 3);
        board_ack(1, 0, 0, 2);
        check("p1_ack_player", int'(current_player), 1);
        check("p1_ack_trst", int'(timer_reset), 1);
        tick();
        check("trst_one_cycle", int'(timer_reset), 0);

        player_move(1, 5, 0, 1);
        board_ack(1, 0, 0, 0);
        tick();

        player_move(0, 2, 0, 1);
        board_ack(0, 0, 0, 1);
        check("illegal_player", int'(current_player), 0);
        check("illegal_no_trst", int'(timer_reset), 0);
        tick();

        // Move and timeout in the same cycle: move wins
        player_move(0, 2, 1, 1);
        check("move_beats_to", int'(move_col), 2);
        board_ack(1, 0, 0, 0);
        tick();

        // Auto move for P2 starting at column 6
        k = 0;
        while ((int'(seq[n_edges % 255]) % NC) != 6 && k < 300) begin
            tick();
            k++;
        end
        check("lfsr_wait_bound", int'(k < 300), 1);
        r0 = n_reqs;
        timeout_now();
        check("auto_first_col", int'(move_col), 6);
        check("auto_player", int'(move_player), 1);
        board_ack(0, 0, 0, 1);
        check("auto_second_col", int'(move_col), 0);
        board_ack(0, 0, 0, 0);
        board_ack(1, 0, 0, 0);
        check("auto_req_count", n_reqs - r0, 3);
        check("auto_toggle", int'(current_player), 0);
        tick();

        // Board rejects every column
        r0 = n_reqs;
        timeout_now();
        for (int i = 0; i < NC; i++) board_ack(0, 0, 0, 0);
        repeat (3) tick();
        check("exhaust_req_count", n_reqs - r0, 7);
        check("exhaust_winner", int'(winner), 3);
        check("exhaust_over", int'(game_over), 1);

        // Restart from DONE; P2 wins with win and draw both set
        start_game();
        player_move(0, 0, 0, 1);
        board_ack(1, 0, 0, 0);
        player_move(1, 4, 0, 1);
        board_ack(1, 1, 1, 1);
        check("p2_win_winner", int'(winner), 2);
        check("p2_win_over", int'(game_over), 1);
        tick();

        // Reset in the middle of a request
        start_game();
        player_move(0, 1, 0, 1);
        tick();
        chk_en = 1'b0;
        rst_n = 1'b0;
        #1;
        check("abort_move_req", int'(move_req), 0);
        check("abort_trst", int'(timer_reset), 1);
        check("abort_ten", int'(timer_enable), 0);
        e_req = 1'b0; e_ten = 1'b0; e_cur = 1'b0; e_over = 1'b0; e_win = 0;
        in_auto = 1'b0; e_trst = 1'b1;
        @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        chk_en = 1'b1;
        stray_ack();
        repeat (3) tick();
        check("abort_no_req", int'(move_req), 0);

        // Plain draw on a legal move
        start_game();
        player_move(0, 6, 0, 1);
        board_ack(1, 0, 1, 0);
        check("draw_winner", int'(winner), 3);
        check("draw_player_held", int'(current_player), 0);
        repeat (2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/turn_scheduler.md
TURN_SCHEDULER -- requirements
Module: turn_scheduler

Interface
REQ-001 SHALL have parameter NUM_COLS, default 7, board column count; COL_W = $clog2(NUM_COLS) derived.
REQ-002 SHALL have port clk  input  1  single system clock.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  begin a new game (level, sampled per cycle).
REQ-005 SHALL have ports p1_move_valid / p2_move_valid  input  1  one-cycle move strobe per player.
REQ-006 SHALL have ports p1_col / p2_col  input  COL_W  requested column, qualified by the matching valid.
REQ-007 SHALL have port timer_timeout  input  1  turn-timer expiry pulse.
REQ-008 SHALL have ports timer_enable / timer_reset  output  1  turn-timer run control / one-cycle clear.
REQ-009 SHALL have ports move_req  output  1, move_col  output  COL_W, move_player  output  1 (0=P1, 1=P2)  board write request.
REQ-010 SHALL have ports move_ack, move_legal, win, draw  input  1  board response; legal/win/draw valid only in the move_ack cycle.
REQ-011 SHALL have ports current_player  output  1, game_over  output  1, winner  output  2 (00 none, 01 P1, 10 P2, 11 draw).

Function
REQ-012 SHALL implement FSM states IDLE, TURN, ISSUE, AUTO, DONE.
REQ-013 IDLE/DONE: start=1 -> TURN with current_player=0, winner=00, game_over=0, timer_reset=1 for that one cycle; start is ignored in TURN/ISSUE/AUTO.
REQ-014 TURN: timer_enable=1; timer_enable=0 in all other states, pausing the timer during board transactions.
REQ-015 TURN: a valid strobe from the current player with col < NUM_COLS latches col and moves to ISSUE; the other player's strobe and out-of-range columns are ignored.
REQ-016 TURN: timer_timeout=1 with no same-cycle valid current-player move -> AUTO; a same-cycle valid move wins over timeout.
REQ-017 ISSUE/AUTO: move_req=1 with stable move_col/move_player from the cycle after entry until and including the move_ack cycle; deasserted the following cycle.
REQ-018 On ack with move_legal=1 and win=1 -> DONE, winner = current player code; with draw=1 (win=0) -> DONE, winner=11; win has priority over draw.
REQ-019 On ack with move_legal=1, no win/draw -> TURN, current_player toggles, timer_reset=1 for exactly one cycle.
REQ-020 On ack with move_legal=0 from ISSUE -> TURN, same player, no timer_reset (remaining time preserved).
REQ-021 AUTO: first column = LFSR value mod NUM_COLS; on illegal ack, column increments with wrap NUM_COLS-1 -> 0 and re-requests; after NUM_COLS illegal attempts -> DONE, winner=11.
REQ-022 LFSR: 8-bit Fibonacci, taps 8,6,5,4, seed 8'hA5, advances every cycle in every state.
REQ-023 game_over=1 exactly while in DONE; current_player holds its last value in DONE.
REQ-024 move_ack outside ISSUE/AUTO SHALL be ignored.

Reset
REQ-025 rst_n=0 SHALL asynchronously force IDLE, current_player=0, winner=00, game_over=0, move_req=0, move_col=0, move_player=0, timer_enable=0, timer_reset=1, attempt counter=0, LFSR=8'hA5.
REQ-026 Reset asserted mid-transaction SHALL abort it; no further move_req until a new start.

Structure
REQ-027 Shared package game_pkg SHALL hold the FSM state enum, winner encodings (WIN_NONE/WIN_P1/WIN_P2/WIN_DRAW) and the default NUM_COLS constant.
REQ-028 The LFSR SHALL be a separate sub-module lfsr8 (clk, rst_n, value[7:0]).
REQ-029 All outputs SHALL be registered.

Verification
REQ-030 start; P1 col 3, ack legal -> move_req col 3 player 0, then current_player=1, one-cycle timer_reset.
REQ-031 In TURN, P2 strobes while P1's turn -> no move_req, state stays TURN, timer_enable stays 1.
REQ-032 P1 col 2, ack legal=0 -> back to TURN, current_player=0, timer_reset stays 0.
REQ-033 timer_timeout with LFSR mod 7 = 6; board rejects 6 and 0, accepts 1 -> three requests with cols 6, 0, 1, then player toggles.
REQ-034 Timeout, board rejects all 7 columns -> exactly 7 requests, then game_over=1, winner=11.
REQ-035 Ack legal with win=1 and draw=1 on P2's move -> winner=10, game_over=1; rst_n low mid-ISSUE -> move_req=0 immediately, IDLE.
